// File: rtl/event_log_ring_regs.sv
// Circular event-word log with byte-wise register read port and delayed access acknowledge.
// Build option: EVENT_LOG_STOP_ON_FULL_EN drops pushes into a full log instead of overwriting.
module event_log_ring_regs #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32,
    parameter int ACCESS_DLY = 4
) (
    input  logic                                          iClk,
    input  logic                                          iRst,
    input  logic                                          iEnable,
    output logic                                          oAccessDone,
    input  logic                                          iAppWE,
    input  logic [DATA_W-1:0]                             ivAppData,
    input  logic                                          iAppDataRst,
    input  logic [DEPTH_LOG2+$clog2(DATA_W/8)-1:0]        ivRegID,
    output logic [7:0]                                    ovRegData,
    output logic [DEPTH_LOG2-1:0]                         ovWrPtr,
    output logic [DEPTH_LOG2:0]                           ovCount,
    output logic                                          oWrapped
);

    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int BYTES     = DATA_W / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int ADDR_W    = DEPTH_LOG2 + LANE_BITS;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     rdWord_p1;
    logic [DEPTH_LOG2-1:0] rdAddr_p0;
    logic [1:0]            lane_p0;
    logic [1:0]            lane_p1;
    logic [7:0]            regData_p2;
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2:0]   count;
    logic                  wrapped;
    logic                  isFull;
    logic                  memWe;
    logic [ACCESS_DLY-1:0] doneSr;

    function automatic logic [7:0] selectByte(input logic [DATA_W-1:0] word,
                                              input logic [1:0] lane);
        logic [DATA_W-1:0] shifted;
        shifted = word >> {lane, 3'b000};
        return shifted[7:0];
    endfunction

    assign rdAddr_p0 = ivRegID[ADDR_W-1:LANE_BITS];

    generate
        if (LANE_BITS > 0) begin : gLane
            assign lane_p0 = 2'(ivRegID[LANE_BITS-1:0]);
        end else begin : gNoLane
            assign lane_p0 = 2'b00;
        end
    endgenerate

    assign isFull = (count == FULL_COUNT);

`ifdef EVENT_LOG_STOP_ON_FULL_EN
    assign memWe = iRst && !iAppDataRst && iAppWE && !isFull;
`else
    assign memWe = iRst && !iAppDataRst && iAppWE;
`endif

    // Pointer, fill count and sticky wrap/lost flag; clear outranks a push.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            wrPtr   <= '0;
            count   <= '0;
            wrapped <= 1'b0;
        end else if (iAppDataRst) begin
            wrPtr   <= '0;
            count   <= '0;
            wrapped <= 1'b0;
        end else if (iAppWE) begin
`ifdef EVENT_LOG_STOP_ON_FULL_EN
            if (isFull) begin
                wrapped <= 1'b1;
            end else begin
                wrPtr <= wrPtr + 1'b1;
                count <= count + 1'b1;
            end
`else
            wrPtr <= wrPtr + 1'b1;
            if (isFull) begin
                wrapped <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
`endif
        end
    end

    // Stage p0 -> p1: BRAM port, read-before-write on a same-word collision.
    always_ff @(posedge iClk) begin
        if (memWe) begin
            mem[wrPtr] <= ivAppData;
        end
        rdWord_p1 <= mem[rdAddr_p0];
        lane_p1   <= lane_p0;
    end

    // Stage p1 -> p2: byte-lane select into the output register.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            regData_p2 <= 8'h00;
        end else begin
            regData_p2 <= selectByte(rdWord_p1, lane_p1);
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            doneSr <= '0;
        end else begin
            doneSr <= {doneSr[ACCESS_DLY-2:0], iEnable};
        end
    end

    assign oAccessDone = doneSr[ACCESS_DLY-1];
    assign ovRegData   = regData_p2;
    assign ovWrPtr     = wrPtr;
    assign ovCount     = count;
    assign oWrapped    = wrapped;

endmodule

// File: tb/tb_event_log_ring_regs.sv
// Bench for event_log_ring_regs: directed scenarios plus a randomized run against an array/queue model.
module tb_event_log_ring_regs;

    localparam int DEPTH_LOG2 = 2;
    localparam int DATA_W     = 32;
    localparam int ACCESS_DLY = 4;
    localparam int DEPTH      = 4;

    logic        iClk;
    logic        iRst;
    logic        iEnable;
    logic        oAccessDone;
    logic        iAppWE;
    logic [31:0] ivAppData;
    logic        iAppDataRst;
    logic [3:0]  ivRegID;
    logic [7:0]  ovRegData;
    logic [1:0]  ovWrPtr;
    logic [2:0]  ovCount;
    logic        oWrapped;

    event_log_ring_regs #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .DATA_W(DATA_W),
        .ACCESS_DLY(ACCESS_DLY)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iEnable(iEnable),
        .oAccessDone(oAccessDone),
        .iAppWE(iAppWE),
        .ivAppData(ivAppData),
        .iAppDataRst(iAppDataRst),
        .ivRegID(ivRegID),
        .ovRegData(ovRegData),
        .ovWrPtr(ovWrPtr),
        .ovCount(ovCount),
        .oWrapped(oWrapped)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mMem [DEPTH];
    bit          mValid [DEPTH];
    int          mPtr = 0;
    int          mCount = 0;
    bit          mWrapped = 0;
    logic [7:0]  rdPend = 8'h00;
    bit          rdPendV = 0;
    logic [7:0]  ovExp = 8'h00;
    bit          ovExpV = 0;
    bit          enAt [4096];
    int          edgeNo = 0;
    int          lastRst = 0;

    function automatic logic [7:0] byteOf(input logic [31:0] w, input int lane);
        logic [31:0] s;
        s = w >> (8 * lane);
        return s[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelPush();
        mMem[mPtr]   = ivAppData;
        mValid[mPtr] = 1'b1;
        mPtr         = (mPtr + 1) % DEPTH;
    endtask

    // One clock: advance the model from the current inputs, clock the DUT, compare.
    task automatic step();
        int         w;
        int         ln;
        int         idx;
        logic [7:0] rdNow;
        bit         rdNowV;
        bit         expDone;
        edgeNo++;
        w      = int'(ivRegID) / 4;
        ln     = int'(ivRegID) % 4;
        rdNow  = byteOf(mMem[w], ln);
        rdNowV = mValid[w];
        if (!iRst) begin
            ovExp  = 8'h00;
            ovExpV = 1'b1;
            lastRst = edgeNo;
            enAt[edgeNo] = 1'b0;
            mPtr = 0; mCount = 0; mWrapped = 0;
        end else begin
            ovExp  = rdPend;
            ovExpV = rdPendV;
            enAt[edgeNo] = iEnable;
            if (iAppDataRst) begin
                mPtr = 0; mCount = 0; mWrapped = 0;
            end else if (iAppWE) begin
                if (mCount == DEPTH) begin
                    mWrapped = 1'b1;
`ifndef EVENT_LOG_STOP_ON_FULL_EN
                    modelPush();
`endif
                end else begin
                    modelPush();
                    mCount++;
                end
            end
        end
        rdPend  = rdNow;
        rdPendV = rdNowV;
        @(posedge iClk);
        #1;
        idx = edgeNo - ACCESS_DLY + 1;
        expDone = (idx > lastRst) ? enAt[idx] : 1'b0;
        chk("wrPtr", 32'(ovWrPtr), 32'(mPtr));
        chk("count", 32'(ovCount), 32'(mCount));
        chk("wrapped", 32'(oWrapped), 32'(mWrapped));
        chk("accessDone", 32'(oAccessDone), 32'(expDone));
        if (ovExpV) chk("regData", 32'(ovRegData), 32'(ovExp));
    endtask

    task automatic push(input logic [31:0] d);
        iAppWE    = 1'b1;
        ivAppData = d;
        step();
        iAppWE    = 1'b0;
    endtask

    logic [31:0] d [5];
    logic [7:0]  t2Bytes [4];
    logic [31:0] oldW2;
    logic [31:0] newW2;
    logic [31:0] w0Exp;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mMem[i]   = '0;
            mValid[i] = 1'b0;
        end
        iRst = 1'b0; iEnable = 1'b0; iAppWE = 1'b1; ivAppData = $urandom;
        iAppDataRst = 1'b0; ivRegID = 4'd0;

        // Reset held two cycles with a push request present
        step();
        step();
        chk("rst_regData", 32'(ovRegData), 32'h0);
        chk("rst_wrPtr", 32'(ovWrPtr), 32'h0);
        chk("rst_count", 32'(ovCount), 32'h0);
        iRst = 1'b1; iAppWE = 1'b0;

        // Three pushes, then byte-wise little-endian readback of word 0
        d[0] = 32'hA1B2C3D4;
        for (int i = 1; i < 5; i++) d[i] = $urandom;
        for (int i = 0; i < 3; i++) push(d[i]);
        chk("t2_wrPtr", 32'(ovWrPtr), 32'd3);
        chk("t2_count", 32'(ovCount), 32'd3);
        t2Bytes[0] = 8'hD4; t2Bytes[1] = 8'hC3; t2Bytes[2] = 8'hB2; t2Bytes[3] = 8'hA1;
        for (int k = 0; k < 4; k++) begin
            ivRegID = 4'(k);
            step();
            step();
            chk("t2_byte", 32'(ovRegData), 32'(t2Bytes[k]));
        end

        // Fill past capacity
        push(d[3]);
        push(d[4]);
`ifdef EVENT_LOG_STOP_ON_FULL_EN
        chk("t3_wrPtr", 32'(ovWrPtr), 32'd0);
        w0Exp = d[0];
`else
        chk("t3_wrPtr", 32'(ovWrPtr), 32'd1);
        w0Exp = d[4];
`endif
        chk("t3_count", 32'(ovCount), 32'd4);
        chk("t3_wrapped", 32'(oWrapped), 32'd1);
        for (int k = 0; k < 4; k++) begin
            ivRegID = 4'(k);
            step();
            step();
            chk("t3_word0", 32'(ovRegData), 32'(byteOf(w0Exp, k)));
        end

        // Clear colliding with a push
        iAppDataRst = 1'b1; step(); iAppDataRst = 1'b0;
        push($urandom);
        push($urandom);
        chk("t4_countPre", 32'(ovCount), 32'd2);
        iAppDataRst = 1'b1; iAppWE = 1'b1; ivAppData = $urandom;
        step();
        iAppDataRst = 1'b0; iAppWE = 1'b0;
        chk("t4_count", 32'(ovCount), 32'd0);
        chk("t4_wrPtr", 32'(ovWrPtr), 32'd0);
        chk("t4_wrapped", 32'(oWrapped), 32'd0);

        // Access acknowledge: six-cycle enable, then one cancelled by reset
        iEnable = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            chk("t5_done", 32'(oAccessDone), 32'((i >= 4) && (i <= 9)));
            if (i == 6) iEnable = 1'b0;
        end
        iEnable = 1'b1;
        step();
        iRst = 1'b0; iEnable = 1'b0;
        step();
        iRst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_doneCancel", 32'(oAccessDone), 32'd0);
        end

        // Read/write collision on word 2
        oldW2 = $urandom;
        newW2 = ~oldW2;
        push($urandom);
        push($urandom);
        push(oldW2);
        iAppDataRst = 1'b1; step(); iAppDataRst = 1'b0;
        push($urandom);
        push($urandom);
        ivRegID = 4'd8;
        push(newW2);
        step();
        chk("t6_oldByte", 32'(ovRegData), 32'(oldW2[7:0]));
        step();
        chk("t6_newByte", 32'(ovRegData), 32'(newW2[7:0]));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            iRst        = ($urandom_range(0, 49) != 0);
            iAppWE      = $urandom_range(0, 1);
            iAppDataRst = ($urandom_range(0, 19) == 0);
            ivAppData   = $urandom;
            if ($urandom_range(0, 3) == 0) iEnable = ~iEnable;
            if ($urandom_range(0, 3) == 0) ivRegID = 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
